// File: rtl/bounded_random_generator_pkg.sv
// Shared types and helpers for the bounded random generator: FSM states,
// LFSR tap selection and parameter legality.
package random_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_DRAW     = 2'd2
    } state_e;

    localparam int unsigned MIN_N = 4;
    localparam int unsigned MAX_N = 8;

    // Feedback taps of a maximal-length Fibonacci LFSR, one bit per tap
    function automatic logic [7:0] tap_mask(input int unsigned n);
        logic [7:0] mask;
        mask = 8'h00;
        case (n)
            4:       mask = 8'b0000_1100;
            5:       mask = 8'b0001_0100;
            6:       mask = 8'b0011_0000;
            7:       mask = 8'b0110_0000;
            8:       mask = 8'b1011_1000;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    function automatic bit params_ok(input int unsigned n, input int unsigned limit);
        return (n >= MIN_N) && (n <= MAX_N) &&
               (limit >= 1) && (limit <= ((32'd1 << n) - 32'd1));
    endfunction

endpackage

// File: rtl/bounded_random_generator_lfsr_step.sv
// One combinational step of the Fibonacci LFSR: shift left, feed back the
// parity of the tapped bits into bit 0.
module lfsr_step
    import random_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0] i_lfsr,
    output logic [N-1:0] o_next
);

    localparam logic [N-1:0] TAP_MASK = N'(tap_mask(N));

    assign o_next = {i_lfsr[N-2:0], ^(i_lfsr & TAP_MASK)};

endmodule

// File: rtl/bounded_random_generator.sv
// Seeded LFSR that answers one-cycle requests with a value in 0..LIMIT-1,
// stepping past (rejecting) LFSR states above LIMIT.
module bounded_random_generator
    import random_pkg::*;
#(
    parameter int unsigned N     = 6,
    parameter int unsigned LIMIT = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] seed,
    input  logic         load,
    input  logic         req,
    output logic         ready,
    output logic [N-1:0] rnd,
    output logic         rnd_valid
);

    if (!params_ok(N, LIMIT)) begin : g_bad_params
        $error("bounded_random_generator: N must be 4..8 and LIMIT 1..2^N-1");
    end

    localparam logic [N-1:0] LIMIT_N = N'(LIMIT);

    state_e       r_state;
    logic [N-1:0] r_lfsr;
    logic [N-1:0] r_rnd;
    logic         r_rnd_valid;
    logic         r_ready;

    logic [N-1:0] w_next;
    logic         w_accept;

    lfsr_step #(.N(N)) u_lfsr_step (
        .i_lfsr (r_lfsr),
        .o_next (w_next)
    );

    // LFSR never holds zero, so an accepted state maps onto 0..LIMIT-1
    assign w_accept = (w_next <= LIMIT_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_UNSEEDED;
            r_lfsr      <= '1;
            r_rnd       <= '0;
            r_rnd_valid <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_rnd_valid <= 1'b0;
            if (load) begin
                // a zero seed would lock the LFSR, so substitute all ones
                r_lfsr  <= (seed == '0) ? '1 : seed;
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req) begin
                            r_state <= ST_DRAW;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_DRAW: begin
                        r_lfsr <= w_next;
                        if (w_accept) begin
                            r_rnd       <= w_next - N'(1);
                            r_rnd_valid <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_ready     <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_UNSEEDED;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready     = r_ready;
    assign rnd       = r_rnd;
    assign rnd_valid = r_rnd_valid;

endmodule

// File: tb/tb_bounded_random_generator.sv
// Directed bench: N=6/LIMIT=36 and N=4/LIMIT=15 instances with hand-traced
// LFSR sequences.
module tb_bounded_random_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] a_seed;
    logic       a_load, a_req, a_ready, a_valid;
    logic [5:0] a_rnd;
    logic [3:0] b_seed;
    logic       b_load, b_req, b_ready, b_valid;
    logic [3:0] b_rnd;

    int total = 0;
    int bad   = 0;

    bounded_random_generator #(.N(6), .LIMIT(36)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .seed      (a_seed),
        .load      (a_load),
        .req       (a_req),
        .ready     (a_ready),
        .rnd       (a_rnd),
        .rnd_valid (a_valid)
    );

    bounded_random_generator #(.N(4), .LIMIT(15)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .seed      (b_seed),
        .load      (b_load),
        .req       (b_req),
        .ready     (b_ready),
        .rnd       (b_rnd),
        .rnd_valid (b_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = edges after the request edge until rnd_valid is seen, -1 on timeout
    task automatic draw_a(output int lat);
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        lat = 0;
        while (!a_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!a_valid) lat = -1;
    endtask

    task automatic draw_b(output int lat);
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
        lat = 0;
        while (!b_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!b_valid) lat = -1;
    endtask

    initial begin
        int         lat;
        int         cnt_ready, cnt_valid, got, cyc, out_of_range, dups;
        logic [63:0] seen;
        logic [15:0] seen_b;

        reset  = 1'b1;
        a_seed = '0; a_load = 1'b0; a_req = 1'b0;
        b_seed = '0; b_load = 1'b0; b_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ready", 32'(a_ready), 32'd0);
        chk("reset_valid", 32'(a_valid), 32'd0);
        chk("reset_rnd",   32'(a_rnd),   32'd0);

        // requests without a seed are ignored
        cnt_ready = 0; cnt_valid = 0;
        a_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_ready) cnt_ready++;
            if (a_valid) cnt_valid++;
        end
        a_req = 1'b0;
        chk("unseeded_ready", 32'(cnt_ready), 32'd0);
        chk("unseeded_valid", 32'(cnt_valid), 32'd0);
        chk("unseeded_rnd",   32'(a_rnd),     32'd0);

        // seed 0 -> 63: 62,60,56,48 rejected, 32 accepted
        a_seed = 6'd0; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        chk("load0_ready", 32'(a_ready), 32'd1);
        chk("load0_valid", 32'(a_valid), 32'd0);
        draw_a(lat);
        chk("seed0_lat", 32'(lat),   32'd5);
        chk("seed0_rnd", 32'(a_rnd), 32'd31);
        chk("seed0_ready_with_valid", 32'(a_ready), 32'd1);
        tick();
        chk("valid_one_cycle", 32'(a_valid), 32'd0);
        draw_a(lat);
        chk("seed0_2nd_lat", 32'(lat),   32'd1);
        chk("seed0_2nd_rnd", 32'(a_rnd), 32'd0);

        // seed 1 -> 2 accepted immediately
        a_seed = 6'd1; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        draw_a(lat);
        chk("seed1_lat", 32'(lat),   32'd1);
        chk("seed1_rnd", 32'(a_rnd), 32'd1);

        // back-to-back: req held high, taken on every ready cycle
        seen = '0; got = 0; cyc = 0; out_of_range = 0; dups = 0;
        a_req = 1'b1;
        while (got < 35 && cyc < 5000) begin
            tick();
            cyc++;
            if (a_valid) begin
                if (a_rnd >= 6'd36) out_of_range++;
                if (seen[a_rnd]) dups++;
                seen[a_rnd] = 1'b1;
                got++;
                if (got == 35) a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        chk("b2b_count",        32'(got),          32'd35);
        chk("b2b_out_of_range", 32'(out_of_range), 32'd0);
        chk("b2b_duplicates",   32'(dups),         32'd0);
        tick();
        chk("b2b_idle_ready", 32'(a_ready), 32'd1);

        // load wins over a simultaneous req
        a_seed = 6'd1; a_load = 1'b1; a_req = 1'b1;
        tick();
        a_load = 1'b0; a_req = 1'b0;
        chk("load_req_ready", 32'(a_ready), 32'd1);
        chk("load_req_valid", 32'(a_valid), 32'd0);
        tick();
        chk("load_req_dropped_ready", 32'(a_ready), 32'd1);
        chk("load_req_dropped_valid", 32'(a_valid), 32'd0);

        // load in the middle of a multi-step draw aborts it
        a_seed = 6'd0; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        tick();
        a_seed = 6'd0; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        chk("abort_ready", 32'(a_ready), 32'd1);
        cnt_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_valid) cnt_valid++;
        end
        chk("abort_no_valid", 32'(cnt_valid), 32'd0);
        draw_a(lat);
        chk("abort_redraw_lat", 32'(lat),   32'd5);
        chk("abort_redraw_rnd", 32'(a_rnd), 32'd31);

        // reset in the middle of a draw
        a_seed = 6'd0; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_ready", 32'(a_ready), 32'd0);
        chk("mid_reset_valid", 32'(a_valid), 32'd0);
        chk("mid_reset_rnd",   32'(a_rnd),   32'd0);
        cnt_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_valid) cnt_valid++;
        end
        chk("mid_reset_no_valid", 32'(cnt_valid), 32'd0);

        // N=4, LIMIT=15: full period from seed 5, every value once, no rejects
        b_seed = 4'd5; b_load = 1'b1;
        tick();
        b_load = 1'b0;
        draw_b(lat);
        chk("n4_first_lat", 32'(lat),   32'd1);
        chk("n4_first_rnd", 32'(b_rnd), 32'd10);
        seen_b = '0;
        seen_b[b_rnd] = 1'b1;
        for (int i = 1; i < 15; i++) begin
            draw_b(lat);
            chk($sformatf("n4_lat_%0d", i), 32'(lat), 32'd1);
            seen_b[b_rnd] = 1'b1;
        end
        chk("n4_coverage", 32'(seen_b), 32'h7fff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
